bubble_pop_scorer: RTL and testbench

- Sits directly downstream of the bubble manager.
- On each fire event it snapshots the shot column of the four bubble rows and walks it bottom-up, one row per cycle, counting pops and awarding combo points.
- It then adds the shot's points into a 4-digit BCD score, one digit per cycle, saturating at 9999.
- score_bcd feeds the seven-segment/score display.

---
 rtl/bubble_pkg.sv | 12 +
 rtl/bcd_digit_add.sv | 14 +
 rtl/bubble_pop_scorer.sv | 99 +++++++++
 tb/tb_bubble_pop_scorer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/bubble_pkg.sv
// bubble_pkg: shared bubble codes, playfield geometry and scorer state encoding
package bubble_pkg;
  localparam int DATA_LEN = 5;
  localparam int ROWS = 4;
  localparam int COLS = 8;
  localparam logic [DATA_LEN-1:0] R_BUBBLE = 5'd16;
  localparam logic [DATA_LEN-1:0] G_BUBBLE = 5'd17;
  localparam logic [DATA_LEN-1:0] B_BUBBLE = 5'd18;
  localparam logic [DATA_LEN-1:0] DARK = 5'd31;
  localparam logic [15:0] BCD_MAX = 16'h9999;
  typedef enum logic [1:0] {IDLE, SCAN, ADD, DONE} state_t;
endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: one BCD digit plus a binary 0-10 addend, with decimal carry out
module bcd_digit_add (
  input  logic [3:0] digit,
  input  logic [3:0] addend,
  output logic [3:0] sum,
  output logic       carry
);
  logic [4:0] raw;
  always_comb begin
    raw = {1'b0, digit} + {1'b0, addend};
    carry = raw > 5'd9;
    sum = carry ? 4'(raw - 5'd10) : raw[3:0];
  end
endmodule

// File: rtl/bubble_pop_scorer.sv
// bubble_pop_scorer: walks the shot column bottom-up scoring combo pops, then
// serially adds the shot's points into a saturating 4-digit BCD score
module bubble_pop_scorer #(
  parameter logic [15:0] INIT_SCORE = 16'h0000,
  parameter int          DATA_LEN   = bubble_pkg::DATA_LEN
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic                                  fire,
  input  logic [2:0]                            shoot_pos,
  input  logic [bubble_pkg::COLS*DATA_LEN-1:0]  BubbleRow1,
  input  logic [bubble_pkg::COLS*DATA_LEN-1:0]  BubbleRow2,
  input  logic [bubble_pkg::COLS*DATA_LEN-1:0]  BubbleRow3,
  input  logic [bubble_pkg::COLS*DATA_LEN-1:0]  BubbleRow4,
  output logic                                  busy,
  output logic                                  done,
  output logic [2:0]                            pop_count,
  output logic [3:0]                            shot_points,
  output logic [15:0]                           score_bcd,
  output logic                                  saturated
);
  import bubble_pkg::*;
  state_t state, state_n;
  logic [1:0] idx;
  logic [DATA_LEN-1:0] col [ROWS];
  logic [DATA_LEN-1:0] run_col, code;
  logic [2:0] run, run_n;
  logic carry, cout, valid, dark;
  logic [3:0] addend, dsum;
  always_comb begin
    code = col[idx];
    dark = code == DARK;
    valid = code == R_BUBBLE || code == G_BUBBLE || code == B_BUBBLE;
    run_n = code == run_col ? run + 3'd1 : 3'd1;
    addend = idx == 2'd0 ? shot_points : {3'b000, carry};
    state_n = !en ? state :
              state == IDLE ? (fire ? SCAN : IDLE) :
              state == SCAN ? (&idx ? ADD : SCAN) :
              state == ADD  ? (&idx ? DONE : ADD) : IDLE;
  end
  bcd_digit_add u_add (
    .digit (score_bcd[{idx, 2'b00} +: 4]),
    .addend(addend),
    .sum   (dsum),
    .carry (cout)
  );
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      col <= '{default: '0};
      run <= '0;
      run_col <= '0;
      carry <= 1'b0;
      pop_count <= '0;
      shot_points <= '0;
      score_bcd <= INIT_SCORE;
      saturated <= 1'b0;
    end else if (en) begin
      state <= state_n;
      case (state)
        IDLE: if (fire) begin
          col[0] <= BubbleRow4[int'(shoot_pos)*DATA_LEN +: DATA_LEN];
          col[1] <= BubbleRow3[int'(shoot_pos)*DATA_LEN +: DATA_LEN];
          col[2] <= BubbleRow2[int'(shoot_pos)*DATA_LEN +: DATA_LEN];
          col[3] <= BubbleRow1[int'(shoot_pos)*DATA_LEN +: DATA_LEN];
          idx <= '0;
          run <= '0;
          run_col <= '0;
          pop_count <= '0;
          shot_points <= '0;
        end
        SCAN: begin
          idx <= idx + 2'd1;
          if (valid) begin
            run <= run_n;
            run_col <= code;
            pop_count <= pop_count + 3'd1;
            shot_points <= shot_points + 4'(run_n);
          end else if (!dark) run <= '0;
        end
        ADD: begin
          idx <= idx + 2'd1;
          carry <= cout;
          score_bcd[{idx, 2'b00} +: 4] <= dsum;
          // a carry out of the thousands digit clamps the whole score
          if (&idx && cout) begin
            score_bcd <= BCD_MAX;
            saturated <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bubble_pop_scorer.sv
// tb_bubble_pop_scorer: directed shots against three scorers with different
// starting scores; a queue-based monitor checks every done pulse
module tb_bubble_pop_scorer;
  localparam logic [4:0] R = 5'd16, G = 5'd17, B = 5'd18, D = 5'd31;
  typedef struct {
    logic [2:0]  pop;
    logic [3:0]  pts;
    logic [15:0] score;
    logic        sat;
    int          cyc;
  } exp_t;
  logic clk = 0, rst = 0, en = 1;
  logic fire [3];
  logic [2:0] shoot_pos = '0;
  logic [39:0] row1 = '0, row2 = '0, row3 = '0, row4 = '0;
  logic busy_w [3], done_w [3], sat_w [3];
  logic [2:0] pop_w [3];
  logic [3:0] pts_w [3];
  logic [15:0] score_w [3];
  exp_t sbq [3][$];
  exp_t e;
  int checks = 0, errors = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    bubble_pop_scorer #(.INIT_SCORE(g == 0 ? 16'h0000 : g == 1 ? 16'h9995 : 16'h0995)) dut (
      .clk(clk), .rst(rst), .en(en), .fire(fire[g]), .shoot_pos(shoot_pos),
      .BubbleRow1(row1), .BubbleRow2(row2), .BubbleRow3(row3), .BubbleRow4(row4),
      .busy(busy_w[g]), .done(done_w[g]), .pop_count(pop_w[g]), .shot_points(pts_w[g]),
      .score_bcd(score_w[g]), .saturated(sat_w[g])
    );
  end
  function automatic logic [15:0] init_of(input int k);
    return k == 0 ? 16'h0000 : k == 1 ? 16'h9995 : 16'h0995;
  endfunction
  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done_w[k]) begin
        if (sbq[k].size() == 0) chk("unexpected_done", k, 32'(cyc), 32'hffffffff);
        else begin
          e = sbq[k].pop_front();
          chk("pop_count", k, 32'(pop_w[k]), 32'(e.pop));
          chk("shot_points", k, 32'(pts_w[k]), 32'(e.pts));
          chk("score_bcd", k, 32'(score_w[k]), 32'(e.score));
          chk("saturated", k, 32'(sat_w[k]), 32'(e.sat));
          chk("done_cycle", k, 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end
  task automatic set_col(input int pos, input logic [4:0] c4, c3, c2, c1);
    for (int j = 0; j < 8; j++) begin
      row4[j*5 +: 5] = j == pos ? c4 : G;
      row3[j*5 +: 5] = j == pos ? c3 : G;
      row2[j*5 +: 5] = j == pos ? c2 : G;
      row1[j*5 +: 5] = j == pos ? c1 : G;
    end
    shoot_pos = 3'(pos);
  endtask
  task automatic wait_idle(input int k);
    int n = 0;
    while (busy_w[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_bound", k, 32'(busy_w[k]), 0);
    @(negedge clk);
  endtask
  task automatic shot(input int k, input int pos, input logic [4:0] c4, c3, c2, c1,
                      input logic [2:0] ep, input logic [3:0] et, input logic [15:0] es, input logic esat);
    set_col(pos, c4, c3, c2, c1);
    sbq[k].push_back('{ep, et, es, esat, cyc + 9});
    fire[k] = 1;
    @(negedge clk);
    fire[k] = 0;
    wait_idle(k);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    for (int k = 0; k < 3; k++) fire[k] = 0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_score", k, 32'(score_w[k]), 32'(init_of(k)));
      chk("rst_busy", k, 32'(busy_w[k]), 0);
      chk("rst_done", k, 32'(done_w[k]), 0);
      chk("rst_sat", k, 32'(sat_w[k]), 0);
      chk("rst_pop", k, 32'(pop_w[k]), 0);
      chk("rst_pts", k, 32'(pts_w[k]), 0);
    end
    rst = 1;
    @(negedge clk);
    shot(0, 3, D, D, D, D, 3'd0, 4'd0, 16'h0000, 1'b0);
    shot(0, 5, R, R, R, R, 3'd4, 4'd10, 16'h0010, 1'b0);
    shot(0, 5, R, R, R, R, 3'd4, 4'd10, 16'h0020, 1'b0);
    shot(0, 0, D, R, G, R, 3'd3, 4'd3, 16'h0023, 1'b0);
    shot(0, 7, G, G, 5'd5, G, 3'd3, 4'd4, 16'h0027, 1'b0);
    shot(1, 1, R, R, R, R, 3'd4, 4'd10, 16'h9999, 1'b1);
    shot(2, 6, R, R, R, R, 3'd4, 4'd10, 16'h1005, 1'b0);
    // second fire while busy, plus a row change after the snapshot
    set_col(2, R, G, B, D);
    sbq[0].push_back('{3'd3, 4'd3, 16'h0030, 1'b0, cyc + 9});
    fire[0] = 1;
    @(negedge clk);
    fire[0] = 0;
    @(negedge clk);
    row4 = '0;
    @(negedge clk);
    set_col(2, G, G, G, G);
    fire[0] = 1;
    @(negedge clk);
    fire[0] = 0;
    chk("busy_midshot", 0, 32'(busy_w[0]), 1);
    wait_idle(0);
    repeat (4) @(negedge clk);
    // enable held low for five cycles inside SCAN
    set_col(4, R, R, R, R);
    sbq[0].push_back('{3'd4, 4'd10, 16'h0040, 1'b0, cyc + 14});
    fire[0] = 1;
    @(negedge clk);
    fire[0] = 0;
    repeat (2) @(negedge clk);
    en = 0;
    repeat (5) begin
      @(negedge clk);
      chk("frozen_pop", 0, 32'(pop_w[0]), 2);
      chk("frozen_pts", 0, 32'(pts_w[0]), 3);
      chk("frozen_busy", 0, 32'(busy_w[0]), 1);
    end
    en = 1;
    wait_idle(0);
    // reset lands during ADD: shot aborted, no done pulse
    set_col(4, R, R, R, R);
    fire[0] = 1;
    @(negedge clk);
    fire[0] = 0;
    repeat (5) @(negedge clk);
    chk("busy_before_rst", 0, 32'(busy_w[0]), 1);
    rst = 0;
    @(negedge clk);
    rst = 1;
    chk("abort_score", 0, 32'(score_w[0]), 0);
    chk("abort_busy", 0, 32'(busy_w[0]), 0);
    chk("abort_pts", 0, 32'(pts_w[0]), 0);
    chk("abort_sat1", 1, 32'(sat_w[1]), 0);
    chk("abort_score1", 1, 32'(score_w[1]), 32'h9995);
    repeat (15) @(negedge clk);
    for (int k = 0; k < 3; k++) chk("pending_done", k, 32'(sbq[k].size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
